// File: rtl/ibex_wb_pkg.sv
// Shared types and width helpers for the Ibex-to-Wishbone pipelined bridge.
package ibex_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } bridge_state_e;

    // Outstanding counter must be able to hold MAX_OUTSTANDING itself.
    function automatic int cnt_width(input int max_outstanding);
        return (max_outstanding < 1) ? 1 : $clog2(max_outstanding + 1);
    endfunction

    // A disabled watchdog still gets a 1-bit register so no zero-width vector appears.
    function automatic int tmr_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/ibex_wb_bridge.sv
// Ibex core port to Wishbone B4 pipelined bridge with outstanding-transaction
// tracking and a response watchdog that drains hung transactions as errors.
module ibex_wb_bridge
    import ibex_wb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    output logic                    gnt,
    output logic                    rvalid,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic                    wb_stall,
    output logic                    abort
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);
    localparam int TW = tmr_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TMO_CNT = TW'(TIMEOUT_CYCLES);

    bridge_state_e   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            abort_q, abort_d;

    logic            full;
    logic            pending;
    logic            resp;

    assign wb_we    = we;
    assign wb_sel   = be;
    assign wb_adr   = addr;
    assign wb_dat_o = wdata;
    assign abort    = abort_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        abort_d = 1'b0;
        gnt     = 1'b0;
        wb_stb  = 1'b0;
        wb_cyc  = 1'b0;
        rvalid  = 1'b0;
        err     = 1'b0;
        rdata   = wb_dat_i;

        full    = (count_q == MAX_CNT);
        pending = (count_q != '0);
        resp    = (wb_ack | wb_err) & pending;

        if (state_q == ABORT) begin
            // Bus is released; each cycle retires one outstanding transaction as an error.
            rvalid  = 1'b1;
            err     = 1'b1;
            rdata   = '0;
            timer_d = '0;
            if (count_q <= CW'(1)) begin
                count_d = '0;
                state_d = IDLE;
            end else begin
                count_d = count_q - CW'(1);
            end
        end else begin
            wb_stb = req & ~full;
            gnt    = wb_stb & ~wb_stall;
            wb_cyc = req | pending;
            rvalid = resp;
            err    = resp & wb_err;

            unique case ({gnt, resp})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            if (TIMEOUT_CYCLES == 0 || !pending || resp) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end

            // A response in the expiry cycle already cleared the watchdog, so it wins.
            if (TIMEOUT_CYCLES != 0 && pending && !resp && timer_q == TMO_CNT) begin
                state_d = ABORT;
                abort_d = 1'b1;
                timer_d = '0;
            end else begin
                state_d = (count_d != '0) ? BUSY : IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: doc/ibex_wb_bridge.md
# ibex_wb_bridge

Parametrised Ibex-to-Wishbone B4 pipelined bridge. It replaces the single-transaction converter between an Ibex instruction or data port and the Wishbone fabric. It supports configurable address and data widths and up to MAX_OUTSTANDING pipelined transactions in flight. A response watchdog aborts a hung bus cycle and returns error responses to the core.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width, core side and bus side.
- DATA_WIDTH, 32: data width, a multiple of 8; SEL_WIDTH = DATA_WIDTH/8.
- MAX_OUTSTANDING, 2: maximum accepted but unanswered transactions, 1..15.
- TIMEOUT_CYCLES, 255: cycles without a response before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  core request.
- gnt  out  1  request accepted this cycle.
- rvalid  out  1  response valid.
- we  in  1  write enable.
- be  in  SEL_WIDTH  byte enables.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data.
- err  out  1  error response, qualified by rvalid.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  write enable.
- wb_sel  out  SEL_WIDTH  byte select.
- wb_adr  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack  in  1  acknowledge.
- wb_err  in  1  bus error.
- wb_stall  in  1  slave stall.
- abort  out  1  one-cycle pulse on entry to ABORT.

## Operation
- States: IDLE (count = 0), BUSY (count > 0), ABORT (draining).
- count is the outstanding counter, width $clog2(MAX_OUTSTANDING+1). full = (count == MAX_OUTSTANDING).
- Transaction acceptance (IDLE or BUSY):
  - wb_stb = req & ~full.
  - gnt = wb_stb & ~wb_stall.
  - wb_adr, wb_we, wb_sel and wb_dat_o pass through addr, we, be and wdata.
- wb_cyc = (req | count != 0) & state != ABORT.
- A response is wb_ack | wb_err, and it counts only when count != 0.
  - On a counted response: rvalid = 1, err = wb_err, rdata = wb_dat_i.
  - Responses arriving with count = 0 are ignored: rvalid = 0.
- Counter update per cycle:
  - gnt and a response together: count unchanged.
  - gnt alone: count + 1.
  - Response alone: count − 1.
- Watchdog timer, width $clog2(TIMEOUT_CYCLES+1):
  - Clears when count = 0 or on any response.
  - Otherwise increments each cycle.
  - When it equals TIMEOUT_CYCLES at a clock edge, the next state is ABORT and abort pulses.
- ABORT:
  - gnt = 0, wb_stb = 0, wb_cyc = 0; bus acks and errors are ignored.
  - Each cycle drives rvalid = 1, err = 1, rdata = 0, and decrements count.
  - When count reaches 0, the next state is IDLE and the timer clears.
- wb_ack and wb_err together: treated as an error response.

## Timing
- Reset values: state IDLE, count 0, timer 0, abort 0.
  - All combinational outputs follow from these: gnt, rvalid, err, wb_cyc and wb_stb are 0; rdata is wb_dat_i when rvalid is 0 in IDLE/BUSY.
- Request to gnt: 0 cycles when not stalled and not full.
- Bus response to rvalid: 0 cycles, purely combinational.
- Abort response rate: one error response per cycle; MAX_OUTSTANDING=2 with count 2 drains in 2 cycles.
- Reset asserted mid-transaction: all state returns to reset values immediately; pending responses are dropped.
- At full, a response in the same cycle does not unblock the strobe; wb_stb reasserts the following cycle.
- TIMEOUT_CYCLES=0: the timer is held at 0 and ABORT is unreachable.

## Structure
- Shared package ibex_wb_pkg holds:
  - the state enum bridge_state_e (IDLE, BUSY, ABORT);
  - the localparam helpers for counter and timer widths.
- No sub-module. The counter, watchdog and FSM are a single always_ff plus one always_comb.

## Test plan
- Single read, no stall: req with addr=0x100; gnt in the same cycle; ack one cycle later with dat_i=0xDEADBEEF -> rvalid=1, rdata=0xDEADBEEF, count back to 0, wb_cyc drops.
- Stall: wb_stall high for 3 cycles -> wb_stb held, gnt=0 for 3 cycles, gnt=1 on cycle 4, count=1.
- Pipelining with MAX_OUTSTANDING=2: 3 back-to-back reqs, acks withheld -> gnt for the first 2, wb_stb=0 for the third until the first ack, responses returned in order.
- Bus error: wb_err on an outstanding write -> rvalid=1, err=1, count decremented.
- Timeout with TIMEOUT_CYCLES=8 and 2 outstanding, no response:
  - abort pulses after 8 idle cycles;
  - then 2 cycles of rvalid=err=1, rdata=0, with wb_cyc=0;
  - then IDLE; a late ack is ignored.
- Reset mid-burst: rst_n low with count=2 -> count=0, wb_cyc=0, state IDLE asynchronously; no rvalid after release.
